tristate_bus_ctrl: RTL and testbench

Parametrised bidirectional bus controller: owns a WIDTH-bit tristate line, sequences direction changes with a programmable number of guaranteed high-impedance turnaround cycles, registers transmit data and exposes receive data with a valid strobe. It sits between the DRAM command/data engines and the DQ/DB pads. It replaces per-bit combinational direction control with a single contention-free direction state machine.

---
 rtl/tristate_bus_pkg.sv | 14 +
 rtl/tristate_bus_pad.sv | 14 +
 rtl/tristate_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_tristate_bus_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// Shared types for the tristate bus controller: direction FSM states and direction encodings.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        StRx   = 2'd0,
        StTaTx = 2'd1,
        StTx   = 2'd2,
        StTaRx = 2'd3
    } state_e;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/tristate_bus_pad.sv
// Pad driver: drives the shared line when enabled and returns the raw line value.
module tristate_bus_pad #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] line
);

    assign line = oe ? dout : {WIDTH{1'bz}};
    assign din  = line;

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Bidirectional bus controller with guaranteed high-Z turnaround between directions.
// Optional TRISTATE_BUS_CTRL_IN_REG_EN registers the receive path (one cycle of latency).
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TA_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dir_valid_i,
    input  logic             dir_tx_i,
    output logic             dir_ready_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic             rx_en_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             is_tx_o,
    output logic             busy_o,
    inout  wire  [WIDTH-1:0] line_io
);

    localparam int unsigned CntW = (TA_CYCLES < 1) ? 1 : $clog2(TA_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(TA_CYCLES - 1);

    if (TA_CYCLES < 1) begin : g_bad_ta
        $error("tristate_bus_ctrl: TA_CYCLES must be >= 1");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [WIDTH-1:0]  line_in;
    logic              oe;
    logic              tx_ready;
    logic              rx_sample;

    // Enable is a pure decode of the state register so reset kills the drive asynchronously.
    assign oe      = (state_q == StTx);
    assign is_tx_o = oe;

    tristate_bus_pad #(
        .WIDTH(WIDTH)
    ) u_pad (
        .oe  (oe),
        .dout(dout_q),
        .din (line_in),
        .line(line_io)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRx;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        dir_ready_o = 1'b0;
        tx_ready    = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            StRx: begin
                dir_ready_o = 1'b1;
                if (dir_valid_i && (dir_tx_i == DIR_TX)) begin
                    state_d = StTaTx;
                    cnt_d   = CntLoad;
                end
            end
            StTaTx: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StTx;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StTx: begin
                dir_ready_o = 1'b1;
                // A turnaround request wins over a same-cycle beat; the beat stalls.
                tx_ready = !(dir_valid_i && (dir_tx_i == DIR_RX));
                if (tx_valid_i && tx_ready) begin
                    dout_d = tx_data_i;
                end
                if (dir_valid_i && (dir_tx_i == DIR_RX)) begin
                    state_d = StTaRx;
                    cnt_d   = CntLoad;
                end
            end
            StTaRx: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StRx;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StRx;
            end
        endcase
    end

    assign tx_ready_o = tx_ready;
    assign rx_sample  = (state_q == StRx) && rx_en_i;

`ifdef TRISTATE_BUS_CTRL_IN_REG_EN
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_sample ? line_in : '0;
            rx_valid_q <= rx_sample;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`else
    // Zero unless sampling in RX so the block never echoes its own drive or a floating line.
    assign rx_data_o  = rx_sample ? line_in : '0;
    assign rx_valid_o = rx_sample;
`endif

`ifndef SYNTHESIS
    a_no_drive_outside_tx: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != StTx) |-> !oe);
`endif

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Directed bench for tristate_bus_ctrl: an 8-bit TA_CYCLES=2 instance and a 32-bit TA_CYCLES=1 one.
module tb_tristate_bus_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: WIDTH=8, TA_CYCLES=2
    logic       a_dir_valid, a_dir_tx, a_dir_ready;
    logic [7:0] a_tx_data;
    logic       a_tx_valid, a_tx_ready;
    logic       a_rx_en;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_is_tx, a_busy;
    wire  [7:0] line8;
    logic [7:0] ext_drv;
    logic       ext_en;

    assign line8 = ext_en ? ext_drv : 8'bz;
    pullup pu8 (line8);

    tristate_bus_ctrl #(
        .WIDTH    (8),
        .TA_CYCLES(2)
    ) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .dir_valid_i(a_dir_valid),
        .dir_tx_i   (a_dir_tx),
        .dir_ready_o(a_dir_ready),
        .tx_data_i  (a_tx_data),
        .tx_valid_i (a_tx_valid),
        .tx_ready_o (a_tx_ready),
        .rx_en_i    (a_rx_en),
        .rx_data_o  (a_rx_data),
        .rx_valid_o (a_rx_valid),
        .is_tx_o    (a_is_tx),
        .busy_o     (a_busy),
        .line_io    (line8)
    );

    // Instance B: WIDTH=32, TA_CYCLES=1
    logic        b_dir_valid, b_dir_tx, b_dir_ready;
    logic [31:0] b_tx_data;
    logic        b_tx_valid, b_tx_ready;
    logic        b_rx_en;
    logic [31:0] b_rx_data;
    logic        b_rx_valid, b_is_tx, b_busy;
    wire  [31:0] line32;

    pullup pu32 (line32);

    tristate_bus_ctrl #(
        .WIDTH    (32),
        .TA_CYCLES(1)
    ) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .dir_valid_i(b_dir_valid),
        .dir_tx_i   (b_dir_tx),
        .dir_ready_o(b_dir_ready),
        .tx_data_i  (b_tx_data),
        .tx_valid_i (b_tx_valid),
        .tx_ready_o (b_tx_ready),
        .rx_en_i    (b_rx_en),
        .rx_data_o  (b_rx_data),
        .rx_valid_o (b_rx_valid),
        .is_tx_o    (b_is_tx),
        .busy_o     (b_busy),
        .line_io    (line32)
    );

    // An undriven line reads as all ones through the pullups.
    localparam logic [7:0]  Z8  = 8'hFF;
    localparam logic [31:0] Z32 = 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        a_dir_valid = 0; a_dir_tx = 0; a_tx_data = '0; a_tx_valid = 0; a_rx_en = 0;
        b_dir_valid = 0; b_dir_tx = 0; b_tx_data = '0; b_tx_valid = 0; b_rx_en = 0;
        ext_drv = '0; ext_en = 0;

        // Reset state
        repeat (2) tick();
        settle();
        check("rst_dir_ready", a_dir_ready, 1);
        check("rst_tx_ready", a_tx_ready, 0);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_rx_data", a_rx_data, 0);
        check("rst_is_tx", a_is_tx, 0);
        check("rst_busy", a_busy, 0);
        check("rst_line", line8, Z8);
        rst = 0;
        tick();

        // RX -> TX with two turnaround cycles
        a_dir_valid = 1; a_dir_tx = 1;
        settle();
        check("rx_dir_ready", a_dir_ready, 1);
        tick();
        a_dir_valid = 0; a_rx_en = 1;
        settle();
        check("ta_tx1_busy", a_busy, 1);
        check("ta_tx1_line", line8, Z8);
        check("ta_tx1_tx_ready", a_tx_ready, 0);
        check("ta_tx1_dir_ready", a_dir_ready, 0);
        check("ta_rx_valid", a_rx_valid, 0);
        tick();
        settle();
        check("ta_tx2_busy", a_busy, 1);
        check("ta_tx2_line", line8, Z8);
        tick();
        settle();
        check("tx_is_tx", a_is_tx, 1);
        check("tx_tx_ready", a_tx_ready, 1);
        check("tx_busy", a_busy, 0);
        check("tx_entry_line", line8, 8'h00);
        check("tx_rx_valid", a_rx_valid, 0);
        a_rx_en = 0;

        // First beat, then back-to-back beats with one-cycle latency
        a_tx_valid = 1; a_tx_data = 8'hA5;
        tick();
        settle();
        check("beat_a5", line8, 8'hA5);
        for (int i = 1; i <= 8; i++) begin
            a_tx_data = 8'(i);
            tick();
            settle();
            check("beat_stream", line8, 32'(i));
        end
        a_tx_valid = 0;
        tick();
        settle();
        check("tx_hold", line8, 8'h08);

        // Turnaround request collides with a beat: the beat stalls
        a_dir_valid = 1; a_dir_tx = 0; a_tx_valid = 1; a_tx_data = 8'h55;
        settle();
        check("collide_tx_ready", a_tx_ready, 0);
        check("collide_dir_ready", a_dir_ready, 1);
        tick();
        a_dir_valid = 0; a_tx_valid = 0;
        settle();
        check("ta_rx1_line", line8, Z8);
        check("ta_rx1_busy", a_busy, 1);
        check("ta_rx1_is_tx", a_is_tx, 0);
        tick();
        settle();
        check("ta_rx2_busy", a_busy, 1);
        check("ta_rx2_line", line8, Z8);
        tick();
        settle();
        check("rx_busy", a_busy, 0);
        check("rx_dir_ready2", a_dir_ready, 1);

        // Receive sample with external drive
        ext_drv = 8'h3C; ext_en = 1; a_rx_en = 1;
        settle();
`ifdef TRISTATE_BUS_CTRL_IN_REG_EN
        check("rx_reg_pre_valid", a_rx_valid, 0);
        tick();
        settle();
`endif
        check("rx_valid", a_rx_valid, 1);
        check("rx_data", a_rx_data, 8'h3C);
        a_rx_en = 0; ext_en = 0;
        tick();
        settle();
        check("rx_idle_valid", a_rx_valid, 0);

        // Back to TX: the stalled 0x55 was never taken
        a_dir_valid = 1; a_dir_tx = 1;
        tick();
        a_dir_valid = 0;
        tick();
        tick();
        settle();
        check("tx2_is_tx", a_is_tx, 1);
        check("tx2_line_held", line8, 8'h08);
        a_tx_valid = 1; a_tx_data = 8'h77;
        tick();
        a_tx_valid = 0;
        settle();
        check("tx2_beat", line8, 8'h77);

        // Reset mid-TX
        rst = 1;
        settle();
        check("rst_tx_line", line8, Z8);
        check("rst_tx_is_tx", a_is_tx, 0);
        check("rst_tx_tx_ready", a_tx_ready, 0);
        check("rst_tx_dir_ready", a_dir_ready, 1);
        rst = 0;
        tick();
        settle();
        check("post_rst_is_tx", a_is_tx, 0);

        // Reset mid-TA_TX
        a_dir_valid = 1; a_dir_tx = 1;
        tick();
        a_dir_valid = 0;
        settle();
        check("pre_rst_ta_busy", a_busy, 1);
        rst = 1;
        settle();
        check("rst_ta_busy", a_busy, 0);
        check("rst_ta_dir_ready", a_dir_ready, 1);
        check("rst_ta_line", line8, Z8);
        rst = 0;
        tick();
        settle();
        check("post_rst_ta_busy", a_busy, 0);

        // After reset the TX entry value is back to zero
        a_dir_valid = 1; a_dir_tx = 1;
        tick();
        a_dir_valid = 0;
        tick();
        tick();
        settle();
        check("tx3_is_tx", a_is_tx, 1);
        check("tx3_line_zero", line8, 8'h00);

        // 32-bit, single turnaround cycle
        b_dir_valid = 1; b_dir_tx = 1;
        tick();
        b_dir_valid = 0;
        settle();
        check("b_ta_tx_busy", b_busy, 1);
        check("b_ta_tx_line", line32, Z32);
        tick();
        settle();
        check("b_tx_is_tx", b_is_tx, 1);
        check("b_tx_entry_line", line32, 32'h0);
        b_tx_valid = 1; b_tx_data = 32'h1234_5678;
        tick();
        b_tx_valid = 0;
        settle();
        check("b_beat", line32, 32'h1234_5678);
        b_dir_valid = 1; b_dir_tx = 0;
        tick();
        b_dir_valid = 0;
        settle();
        check("b_ta_rx_line", line32, Z32);
        check("b_ta_rx_busy", b_busy, 1);
        tick();
        settle();
        check("b_rx_busy", b_busy, 0);
        check("b_rx_is_tx", b_is_tx, 0);
        check("b_rx_dir_ready", b_dir_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
